// File: rtl/imem_access_arbiter_pkg.sv
// Shared types and constants for the instruction-memory access arbiter.
//   - arb_state_e : RUN (fetch and loader arbitrated) / LOCK (loader exclusive)
//   - AW_DEF / DW_DEF / MAX_WAIT_DEF : default address, data and starvation-limit values
//   - PORT_F / PORT_L : index of the fetch and loader bits in the grant vector
//   - cnt_width() : counter width able to hold 0..max
package imem_access_arbiter_pkg;

  localparam int unsigned AW_DEF       = 16;
  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned MAX_WAIT_DEF = 4;

  localparam int unsigned PORT_F = 0;
  localparam int unsigned PORT_L = 1;
  localparam int unsigned NPORTS = 2;

  typedef enum logic {
    RUN  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Bits needed to count from 0 up to and including max (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/imem_access_arbiter_if.sv
// Bus bundle between the fetch stage, the loader, the arbiter and the instruction memory.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants, responses and memory strobes)
//   master : requester/memory view (drives requests and mem_rdata, observes the rest)
interface imem_access_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
);

  // Fetch port (read only)
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;

  // Loader port (read/write, optional lock)
  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_lock;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;

  // Instruction memory side
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    input  l_req, l_we, l_addr, l_wdata, l_lock,
    output l_gnt, l_rvalid, l_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    output l_req, l_we, l_addr, l_wdata, l_lock,
    input  l_gnt, l_rvalid, l_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/imem_starve_counter.sv
// Saturating count of consecutive cycles the fetch port was refused.
//   clk, rst_n : clock, async active-low reset
//   inc        : fetch refused this cycle (count up, saturate at MAX_WAIT)
//   clr        : force count to 0 (highest priority)
//   freeze     : hold current value (beats inc)
//   cnt        : current count
module imem_starve_counter
  import imem_access_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
  parameter int unsigned CW       = cnt_width(MAX_WAIT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  input  logic          freeze,
  output logic [CW-1:0] cnt
);

  logic at_max;

  assign at_max = (cnt == CW'(MAX_WAIT));

  // Clear beats freeze beats increment; increment stops at MAX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!freeze && inc && !at_max) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_access_arbiter.sv
// Shares the single-port instruction memory between the CPU fetch port (read only)
// and the loader port (read/write). Loader has fixed priority, fetch is forced the
// grant after MAX_WAIT consecutive refusals, and l_lock gives the loader exclusive
// access (LOCK state). Read data is registered: rvalid one cycle after the grant.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch, loader and memory signals (slave modport)
//   locked     : 1 while in LOCK (fetch blocked)
// Grants, mem_addr, mem_we and mem_wdata are combinational from requests and state.
module imem_access_arbiter
  import imem_access_arbiter_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  imem_access_arbiter_if.slave  bus,
  output logic                  locked
);

  localparam int unsigned CW = cnt_width(MAX_WAIT);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [NPORTS-1:0] gnt_c;
  logic [CW-1:0]     wait_cnt;
  logic              starved;
  logic              cnt_inc;
  logic              cnt_clr;
  logic              cnt_freeze;
  logic [AW-1:0]     mem_addr_c;
  logic              mem_we_c;
  logic [DW-1:0]     mem_wdata_c;
  logic              f_rvalid_q;
  logic              l_rvalid_q;
  logic [DW-1:0]     f_rdata_q;
  logic [DW-1:0]     l_rdata_q;

  assign starved = (wait_cnt == CW'(MAX_WAIT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: lock follows l_lock level, taking effect at the clock edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.l_lock)  state_d = LOCK;
      LOCK:    if (!bus.l_lock) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Grant decode; gated by rst_n so nothing is granted (or written) while in reset
  always_comb begin
    gnt_c = '0;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (bus.l_req && !(bus.f_req && starved)) begin
            gnt_c[PORT_L] = 1'b1;
          end else if (bus.f_req) begin
            gnt_c[PORT_F] = 1'b1;
          end
        end
        LOCK:    gnt_c[PORT_L] = bus.l_req;
        default: gnt_c = '0;
      endcase
    end
  end

  // Starvation counter control: only counts in RUN, zeroed when leaving RUN for LOCK
  always_comb begin
    cnt_inc    = (state_q == RUN) && bus.f_req && !gnt_c[PORT_F];
    cnt_clr    = ((state_q == RUN) && (gnt_c[PORT_F] || !bus.f_req)) ||
                 ((state_q == RUN) && (state_d == LOCK));
    cnt_freeze = (state_q == LOCK);
  end

  imem_starve_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (CW)
  ) u_starve_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .freeze (cnt_freeze),
    .cnt    (wait_cnt)
  );

  // Memory mux: granted port drives the address, idle drives zeros
  always_comb begin
    mem_addr_c  = '0;
    mem_we_c    = 1'b0;
    mem_wdata_c = '0;
    if (gnt_c[PORT_L]) begin
      mem_addr_c  = bus.l_addr;
      mem_we_c    = bus.l_we;
      mem_wdata_c = bus.l_wdata;
    end else if (gnt_c[PORT_F]) begin
      mem_addr_c  = bus.f_addr;
    end
  end

  // Read responses: capture mem_rdata at the granting edge, hold until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      f_rvalid_q <= gnt_c[PORT_F];
      l_rvalid_q <= gnt_c[PORT_L] && !bus.l_we;
      if (gnt_c[PORT_F]) begin
        f_rdata_q <= bus.mem_rdata;
      end
      if (gnt_c[PORT_L] && !bus.l_we) begin
        l_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.f_gnt     = gnt_c[PORT_F];
  assign bus.l_gnt     = gnt_c[PORT_L];
  assign bus.f_rvalid  = f_rvalid_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.l_rvalid  = l_rvalid_q;
  assign bus.l_rdata   = l_rdata_q;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign locked        = (state_q == LOCK);

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for starvation, lock and mid-stream reset.
// Memory model: 256 words, word(a) = 0xC0DE0000 | a until written.
module tb_imem_access_arbiter;

  logic clk;
  logic rst_n;
  logic locked;

  int checks;
  int errors;

  imem_access_arbiter_if #(.AW(16), .DW(32)) bus ();

  imem_access_arbiter #(
    .AW       (16),
    .DW       (32),
    .MAX_WAIT (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .locked (locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: pattern loaded on the first edge, writes at the clock edge
  logic [31:0] mem [256];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f_req, input logic [15:0] f_addr, input logic l_req,
                       input logic l_we, input logic [15:0] l_addr, input logic [31:0] l_wdata,
                       input logic l_lock);
    bus.f_req   = f_req;
    bus.f_addr  = f_addr;
    bus.l_req   = l_req;
    bus.l_we    = l_we;
    bus.l_addr  = l_addr;
    bus.l_wdata = l_wdata;
    bus.l_lock  = l_lock;
  endtask

  typedef struct {
    logic        f_req;
    logic [15:0] f_addr;
    logic        l_req;
    logic        l_we;
    logic [15:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_lock;
    logic        f_gnt;
    logic        l_gnt;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic        locked;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  logic [9:0] starve_pat;
  logic       prev_l_req;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);

    // f_req f_addr l_req l_we l_addr l_wdata l_lock | f_gnt l_gnt we mem_addr | f_rv f_rd | l_rv l_rd | locked
    vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[2]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 32'hC0DE_0000, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 32'hC0DE_0001, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 32'hC0DE_0002, 1'b0, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF, 1'b0};
    vecs[8]  = '{1'b1, 16'h0003, 1'b1, 1'b0, 16'h0005, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 32'h0,         1'b1, 32'hC0DE_0005, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 32'hC0DE_0003, 1'b0, 32'h0,         1'b0};

    repeat (2) @(negedge clk);
    #1;
    check("reset f_rvalid", 32'(bus.f_rvalid), 32'd0);
    check("reset locked", 32'(locked), 32'd0);
    check("reset f_rdata", bus.f_rdata, 32'h0);
    rst_n = 1'b1;

    // Table: drive at negedge, sample #1 later (registered outputs reflect the previous cycle)
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].l_req, vecs[i].l_we,
            vecs[i].l_addr, vecs[i].l_wdata, vecs[i].l_lock);
      #1;
      check($sformatf("row%0d f_gnt", i), 32'(bus.f_gnt), 32'(vecs[i].f_gnt));
      check($sformatf("row%0d l_gnt", i), 32'(bus.l_gnt), 32'(vecs[i].l_gnt));
      check($sformatf("row%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].mem_we));
      check($sformatf("row%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].mem_addr));
      check($sformatf("row%0d f_rvalid", i), 32'(bus.f_rvalid), 32'(vecs[i].f_rvalid));
      check($sformatf("row%0d l_rvalid", i), 32'(bus.l_rvalid), 32'(vecs[i].l_rvalid));
      check($sformatf("row%0d locked", i), 32'(locked), 32'(vecs[i].locked));
      if (vecs[i].f_rvalid) check($sformatf("row%0d f_rdata", i), bus.f_rdata, vecs[i].f_rdata);
      if (vecs[i].l_rvalid) check($sformatf("row%0d l_rdata", i), bus.l_rdata, vecs[i].l_rdata);
    end

    // Starvation: both held high, fetch forced every fifth cycle (bits 4 and 9)
    starve_pat = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 16'h0007, 1'b1, 1'b0, 16'h0008, 32'h0, 1'b0);
      #1;
      check($sformatf("starve%0d f_gnt", i), 32'(bus.f_gnt), 32'(starve_pat[i]));
      check($sformatf("starve%0d l_gnt", i), 32'(bus.l_gnt), 32'(!starve_pat[i]));
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);

    // Lock raised in a cycle where fetch is granted: that fetch still completes
    @(negedge clk);
    drive(1'b1, 16'h0009, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    #1;
    check("lock entry f_gnt", 32'(bus.f_gnt), 32'd1);
    check("lock entry locked", 32'(locked), 32'd0);
    prev_l_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 16'h0009, 1'(i % 2), 1'b0, 16'h0040 + 16'(i), 32'h0, 1'b1);
      #1;
      check($sformatf("lock%0d locked", i), 32'(locked), 32'd1);
      check($sformatf("lock%0d f_gnt", i), 32'(bus.f_gnt), 32'd0);
      check($sformatf("lock%0d l_gnt", i), 32'(bus.l_gnt), 32'(i % 2));
      check($sformatf("lock%0d l_rvalid", i), 32'(bus.l_rvalid), 32'(prev_l_req));
      if (prev_l_req) check($sformatf("lock%0d l_rdata", i), bus.l_rdata, 32'hC0DE_0040 + 32'(i - 1));
      check($sformatf("lock%0d f_rvalid", i), 32'(bus.f_rvalid), 32'(i == 0));
      if (i == 0) check("lock0 f_rdata", bus.f_rdata, 32'hC0DE_0009);
      prev_l_req = 1'(i % 2);
    end
    // Lock dropped: still LOCK this cycle, fetch granted the next
    @(negedge clk);
    drive(1'b1, 16'h000A, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    #1;
    check("unlock locked", 32'(locked), 32'd1);
    check("unlock f_gnt", 32'(bus.f_gnt), 32'd0);
    @(negedge clk);
    #1;
    check("post-lock locked", 32'(locked), 32'd0);
    check("post-lock f_gnt", 32'(bus.f_gnt), 32'd1);
    // Counter must restart from 0 after the lock: L,L,L,L,F
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 16'h000B, 1'b1, 1'b0, 16'h000C, 32'h0, 1'b0);
      #1;
      check($sformatf("restart%0d f_gnt", i), 32'(bus.f_gnt), 32'(i == 4));
    end

    // Reset mid-stream: fetch granted while lock is requested, then reset with a pending write
    @(negedge clk);
    drive(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    @(negedge clk);
    #1;
    check("pre-reset locked", 32'(locked), 32'd1);
    check("pre-reset f_rvalid", 32'(bus.f_rvalid), 32'd1);
    rst_n = 1'b0;
    drive(1'b1, 16'h0001, 1'b1, 1'b1, 16'h0020, 32'h1234_5678, 1'b0);
    #1;
    check("rst f_rvalid", 32'(bus.f_rvalid), 32'd0);
    check("rst f_rdata", bus.f_rdata, 32'h0);
    check("rst l_rvalid", 32'(bus.l_rvalid), 32'd0);
    check("rst l_rdata", bus.l_rdata, 32'h0);
    check("rst locked", 32'(locked), 32'd0);
    check("rst mem_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    #1;
    check("post-rst f_gnt", 32'(bus.f_gnt), 32'd1);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b0);
    #1;
    check("post-rst f_rvalid", 32'(bus.f_rvalid), 32'd1);
    check("post-rst f_rdata", bus.f_rdata, 32'hC0DE_0001);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    #1;
    check("no write in reset l_rvalid", 32'(bus.l_rvalid), 32'd1);
    check("no write in reset l_rdata", bus.l_rdata, 32'hC0DE_0020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
